// File: rtl/johnson_phase_decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : johnson_phase_decoder_pkg                                |
// | Desc   : Shared FSM state encodings and width helper for the      |
// |          Johnson phase decoder.                                   |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
package johnson_phase_decoder_pkg;

    // Lock FSM state encodings
    localparam logic [0:0] ST_ACQ    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Phase index width for a WIDTH-bit Johnson counter (2*WIDTH states)
    function automatic int phase_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_phase_decoder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : johnson_phase_decoder_if                                 |
// | Desc   : Code input and decoded phase/health outputs of the       |
// |          Johnson phase decoder.                                   |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
interface johnson_phase_decoder_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    import johnson_phase_decoder_pkg::*;

    localparam int PW = phase_w(WIDTH);

    logic [WIDTH-1:0]   jc_in;
    logic               clr_err;
    logic [PW-1:0]      phase;
    logic [2*WIDTH-1:0] onehot;
    logic               legal;
    logic               wrap;
    logic               locked;
    logic               err_pulse;
    logic [ERR_W-1:0]   err_cnt;

    // Side that supplies codes and consumes the decode
    modport master (
        output jc_in, clr_err,
        input  phase, onehot, legal, wrap, locked, err_pulse, err_cnt
    );

    // Decoder side
    modport slave (
        input  jc_in, clr_err,
        output phase, onehot, legal, wrap, locked, err_pulse, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/johnson_phase_decoder_jc_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : johnson_phase_decoder_jc_decode                          |
// | Desc   : Combinational Johnson code check and phase index decode. |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module johnson_phase_decoder_jc_decode #(
    parameter int WIDTH = 4,
    parameter int PW    = 3
) (
    input  wire logic [WIDTH-1:0] i_code,
    output logic                  o_legal,
    output logic [PW-1:0]         o_phase
);

    logic [WIDTH-2:0] w_diff;
    int               w_diff_cnt;
    int               w_ones;

    // Legal codes have at most one 0/1 boundary between adjacent bits;
    // the phase is the fill level, mirrored once the msb is set.
    always_comb begin
        w_diff     = i_code[WIDTH-2:0] ^ i_code[WIDTH-1:1];
        w_diff_cnt = $countones(w_diff);
        w_ones     = $countones(i_code);
        o_legal    = (w_diff_cnt <= 1);
        if (i_code[WIDTH-1]) begin
            o_phase = PW'(2 * WIDTH - w_ones);
        end else begin
            o_phase = PW'(w_ones);
        end
    end

endmodule
`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : johnson_phase_decoder                                    |
// | Desc   : Registers a Johnson counter code, checks legality and    |
// |          step order, decodes phase index / one-hot, tracks lock   |
// |          and counts errors.                                       |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    johnson_phase_decoder_if.slave bus
);

    localparam int PW     = phase_w(WIDTH);
    localparam int NSTATE = 2 * WIDTH;
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);

    logic [WIDTH-1:0]   r_in_q;
    logic               r_in_vld;
    logic               r_first;
    logic [PW-1:0]      r_prev;
    logic [RUN_W-1:0]   r_run;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [PW-1:0]      r_phase;
    logic [NSTATE-1:0]  r_onehot;
    logic               r_legal;
    logic               r_wrap;
    logic               r_err_pulse;
    logic [ERR_W-1:0]   r_err_cnt;

    logic               w_dec_legal;
    logic [PW-1:0]      w_dec_phase;
    logic [PW-1:0]      w_next_prev;
    logic               w_valid_legal;
    logic               w_stepping;
    logic               w_hold;
    logic               w_good;
    logic               w_err;
    logic               w_wrap;
    logic               w_lock_hit;
    logic               w_locked;
    logic [NSTATE-1:0]  w_onehot;

    johnson_phase_decoder_jc_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .i_code  (r_in_q),
        .o_legal (w_dec_legal),
        .o_phase (w_dec_phase)
    );

    // Input capture; r_in_vld keeps the cleared reset value of r_in_q from being decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q   <= '0;
            r_in_vld <= 1'b0;
        end else begin
            r_in_q   <= bus.jc_in;
            r_in_vld <= 1'b1;
        end
    end

    // Step classification of the current code against the previous legal phase
    always_comb begin
        w_next_prev   = (r_prev == PW'(NSTATE - 1)) ? '0 : r_prev + PW'(1);
        w_valid_legal = r_in_vld & w_dec_legal;
        w_stepping    = w_valid_legal & ~r_first;
        w_hold        = w_stepping & (w_dec_phase == r_prev);
        w_good        = w_stepping & (w_dec_phase == w_next_prev);
        w_err         = (r_in_vld & ~w_dec_legal) | (w_stepping & ~w_hold & ~w_good);
        w_wrap        = w_good & (r_prev == PW'(NSTATE - 1));
        w_lock_hit    = w_good & (r_run == RUN_W'(LOCK_CNT - 1));
        for (int i = 0; i < NSTATE; i++) begin
            w_onehot[i] = w_valid_legal & (w_dec_phase == PW'(i));
        end
    end

    // Previous-phase tracker; the first legal code after reset only seeds it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
            r_prev  <= '0;
        end else if (w_valid_legal) begin
            r_first <= 1'b0;
            r_prev  <= w_dec_phase;
        end
    end

    // Consecutive good-step counter used while acquiring lock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= '0;
        end else if (w_err) begin
            r_run <= '0;
        end else if ((r_state == ST_ACQ) && w_good) begin
            r_run <= w_lock_hit ? '0 : r_run + RUN_W'(1);
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACQ: begin
                if (!w_err && w_lock_hit) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_err) begin
                    w_state_nxt = ST_ACQ;
                end
            end
            default: w_state_nxt = ST_ACQ;
        endcase
    end

    // Lock FSM outputs
    always_comb begin
        w_locked = (r_state == ST_LOCKED);
    end

    // Saturating error counter; a clear in the same cycle as an error still counts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (bus.clr_err) begin
            r_err_cnt <= w_err ? ERR_W'(1) : '0;
        end else if (w_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    // Registered decode outputs; phase holds its last legal value on illegal codes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_onehot    <= '0;
            r_legal     <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            if (w_valid_legal) begin
                r_phase <= w_dec_phase;
            end
            r_onehot    <= w_onehot;
            r_legal     <= w_valid_legal;
            r_wrap      <= w_wrap;
            r_err_pulse <= w_err;
        end
    end

    assign bus.phase     = r_phase;
    assign bus.onehot    = r_onehot;
    assign bus.legal     = r_legal;
    assign bus.wrap      = r_wrap;
    assign bus.locked    = w_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_johnson_phase_decoder                                 |
// | Desc   : Self-checking bench: code table plus reference model     |
// |          feeding an expected-output queue.                        |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module tb_johnson_phase_decoder;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 2;
    localparam int ERR_MAX  = 3;

    typedef struct {
        logic [3:0] jc;
        logic       legal;
        logic [2:0] phase;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] phase;
        logic [7:0] onehot;
        logic       legal;
        logic       wrap;
        logic       locked;
        logic       err_pulse;
        logic [1:0] err_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    johnson_phase_decoder_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    johnson_phase_decoder #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT),
        .ERR_W    (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl [16];
    exp_t sbq [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model state
    logic       m_first;
    int         m_prev;
    int         m_run;
    logic       m_locked;
    int         m_cnt;
    logic [2:0] m_phase;
    logic       m_pend;
    logic [3:0] m_pend_code;

    logic [3:0] seqc [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic int find_code(input logic [3:0] jc);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].jc == jc) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_first  = 1'b1;
        m_prev   = 0;
        m_run    = 0;
        m_locked = 1'b0;
        m_cnt    = 0;
        m_phase  = '0;
        m_pend   = 1'b0;
    endtask

    // Expected outputs for one registered code together with this cycle's clr_err
    task automatic model_step(input logic [3:0] code, input logic clr, inout exp_t e);
        int   k;
        int   ph;
        logic err;
        k   = find_code(code);
        err = 1'b0;
        if (!tbl[k].legal) begin
            err = 1'b1;
        end else begin
            ph       = int'(tbl[k].phase);
            m_phase  = tbl[k].phase;
            e.legal  = 1'b1;
            e.onehot = 8'b1 << ph;
            if (m_first) begin
                m_first = 1'b0;
            end else if (ph == m_prev) begin
                // stall: nothing changes
            end else if (ph == (m_prev + 1) % 8) begin
                e.wrap = (m_prev == 7);
                if (!m_locked) begin
                    if (m_run == LOCK_CNT - 1) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                    end else begin
                        m_run++;
                    end
                end
            end else begin
                err = 1'b1;
            end
            m_prev = ph;
        end
        if (err) begin
            m_locked = 1'b0;
            m_run    = 0;
        end
        if (clr) m_cnt = err ? 1 : 0;
        else if (err && m_cnt < ERR_MAX) m_cnt++;
        e.err_pulse = err;
    endtask

    task automatic drive(input logic r, input logic [3:0] jc, input logic clr);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.jc_in   = jc;
        bus.clr_err = clr;
        e           = '{default: '0};
        e.due       = cyc + 1;
        if (r) begin
            model_reset();
        end else begin
            if (m_pend) begin
                model_step(m_pend_code, clr, e);
            end else if (clr) begin
                m_cnt = 0;
            end
            m_pend      = 1'b1;
            m_pend_code = jc;
        end
        e.phase   = m_phase;
        e.locked  = m_locked;
        e.err_cnt = 2'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, seqc[i % 8], 1'b0);
    endtask

    // Output monitor: compare the entry due at this edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("phase",     32'(bus.phase),     32'(e.phase));
            chk("onehot",    32'(bus.onehot),    32'(e.onehot));
            chk("legal",     32'(bus.legal),     32'(e.legal));
            chk("wrap",      32'(bus.wrap),      32'(e.wrap));
            chk("locked",    32'(bus.locked),    32'(e.locked));
            chk("err_pulse", 32'(bus.err_pulse), 32'(e.err_pulse));
            chk("err_cnt",   32'(bus.err_cnt),   32'(e.err_cnt));
        end
    end

    initial begin
        bus.jc_in   = 4'b0000;
        bus.clr_err = 1'b0;
        model_reset();

        tbl[0]  = '{4'b0000, 1'b1, 3'd0};
        tbl[1]  = '{4'b0001, 1'b1, 3'd1};
        tbl[2]  = '{4'b0011, 1'b1, 3'd2};
        tbl[3]  = '{4'b0111, 1'b1, 3'd3};
        tbl[4]  = '{4'b1111, 1'b1, 3'd4};
        tbl[5]  = '{4'b1110, 1'b1, 3'd5};
        tbl[6]  = '{4'b1100, 1'b1, 3'd6};
        tbl[7]  = '{4'b1000, 1'b1, 3'd7};
        tbl[8]  = '{4'b0010, 1'b0, 3'd0};
        tbl[9]  = '{4'b0100, 1'b0, 3'd0};
        tbl[10] = '{4'b0101, 1'b0, 3'd0};
        tbl[11] = '{4'b0110, 1'b0, 3'd0};
        tbl[12] = '{4'b1001, 1'b0, 3'd0};
        tbl[13] = '{4'b1010, 1'b0, 3'd0};
        tbl[14] = '{4'b1011, 1'b0, 3'd0};
        tbl[15] = '{4'b1101, 1'b0, 3'd0};
        for (int i = 0; i < 8; i++) seqc[i] = tbl[i].jc;

        // Reset with an illegal code present, then legal sequence: lock and wraps
        drive(1'b1, 4'b1010, 1'b0);
        drive(1'b1, 4'b1010, 1'b0);
        run_seq(24);

        // Illegal code while locked, then relock
        drive(1'b0, 4'b0101, 1'b0);
        run_seq(16);

        // Stall on 0011 for 3 extra cycles, then skip 0011 -> 1111
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'b0011, 1'b0);
        drive(1'b0, 4'b1111, 1'b0);
        drive(1'b0, 4'b1110, 1'b0);
        drive(1'b0, 4'b1100, 1'b0);

        // Saturation, clear together with an error, clear alone
        drive(1'b0, 4'b0101, 1'b0);
        drive(1'b0, 4'b1010, 1'b0);
        drive(1'b0, 4'b0010, 1'b0);
        drive(1'b0, 4'b0110, 1'b0);
        drive(1'b0, 4'b1001, 1'b0);
        drive(1'b0, 4'b1011, 1'b0);
        drive(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0001, 1'b0);
        drive(1'b0, 4'b0011, 1'b1);
        drive(1'b0, 4'b0111, 1'b0);

        // Reset while locked with a nonzero count; first code after release seeds prev
        drive(1'b0, 4'b0101, 1'b0);
        run_seq(16);
        drive(1'b1, 4'b1100, 1'b0);
        for (int i = 3; i < 3 + 10; i++) drive(1'b0, seqc[i % 8], 1'b0);

        // Every 4-bit code once
        for (int i = 0; i < 16; i++) drive(1'b0, tbl[i].jc, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
